// File: rtl/sram_bist_ctrl_if.sv
// RW0 single-port SRAM bundle: the test initiator drives the request side and the wrapper
// returns registered read data.
interface sram_bist_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport master (output RW0_addr, RW0_en, RW0_wmode, RW0_wdata, input RW0_rdata);
  modport slave  (input RW0_addr, RW0_en, RW0_wmode, RW0_wdata, output RW0_rdata);
endinterface

// File: rtl/sram_bist_ctrl.sv
// March C- BIST initiator on RW0: one op per cycle, reads checked RD_LAT cycles after issue, no backpressure.
// SRAM_BIST_CHECKERBOARD_EN adds a second back-to-back pass with a 0101.. background.
module sram_bist_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              RW0_clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       fail_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  sram_bist_ctrl_if.master  rw0
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        elem;
    logic [DATA_W-1:0] exp;
  } cmp_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] BG_CB    = {(DATA_W/2){2'b01}};
  localparam int                DW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
`ifdef SRAM_BIST_CHECKERBOARD_EN
  localparam logic LAST_PASS = 1'b1;
`else
  localparam logic LAST_PASS = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ph_q, ph_d;
  logic              pas_q, pas_d;
  logic [DW-1:0]     drn_q, drn_d;
  logic [DATA_W-1:0] wdata_q;
  cmp_t              cp_q [RD_LAT];

  logic              run_c, cur_wr_c, down_c, two_op_c, last_addr_c;
  logic              nxt_wr_c, mis_c;
  logic [DATA_W-1:0] cur_exp_c, nxt_wdat_c;

  function automatic logic [DATA_W-1:0] bg(input logic p);
    return p ? BG_CB : '0;
  endfunction

  function automatic logic [ADDR_W-1:0] elem_first(input logic [2:0] e);
    return (e == 3'd3 || e == 3'd4) ? ADDR_MAX : '0;
  endfunction

  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      pas_q   <= 1'b0;
      drn_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      pas_q   <= pas_d;
      drn_q   <= drn_d;
      wdata_q <= rw0.RW0_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    ph_d        = ph_q;
    pas_d       = pas_q;
    drn_d       = drn_q;
    down_c      = (elem_q == 3'd3) || (elem_q == 3'd4);
    two_op_c    = (elem_q != 3'd0) && (elem_q != 3'd5);
    last_addr_c = down_c ? (addr_q == '0) : (addr_q == ADDR_MAX);
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          elem_d  = '0;
          addr_d  = '0;
          ph_d    = 1'b0;
          pas_d   = 1'b0;
        end
      end
      RUN: begin
        if (two_op_c && !ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (!last_addr_c) begin
            addr_d = down_c ? addr_q - 1'b1 : addr_q + 1'b1;
          end else if (elem_q != 3'd5) begin
            elem_d = elem_q + 3'd1;
            addr_d = elem_first(elem_q + 3'd1);
          end else if (pas_q != LAST_PASS) begin
            // next pass follows immediately; in-flight compares keep draining
            pas_d  = 1'b1;
            elem_d = '0;
            addr_d = '0;
          end else begin
            state_d = DRAIN;
            drn_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (drn_q == DW'(RD_LAT - 1)) state_d = DONE;
        else                          drn_d   = drn_q + 1'b1;
      end
      default: ;
    endcase
  end

  // element symbols: odd elements write ~B, elements 2 and 4 read ~B
  assign run_c      = (state_q == RUN);
  assign cur_wr_c   = (elem_q == 3'd0) || ph_q;
  assign cur_exp_c  = (elem_q == 3'd2 || elem_q == 3'd4) ? ~bg(pas_q) : bg(pas_q);
  assign nxt_wr_c   = (state_d == RUN) && ((elem_d == 3'd0) || ph_d);
  assign nxt_wdat_c = elem_d[0] ? ~bg(pas_d) : bg(pas_d);

  // wdata runs one cycle ahead to line up with the wrapper's input data register
  assign rw0.RW0_en    = run_c;
  assign rw0.RW0_wmode = run_c && cur_wr_c;
  assign rw0.RW0_addr  = addr_q;
  assign rw0.RW0_wdata = nxt_wr_c ? nxt_wdat_c : wdata_q;

  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) cp_q[i] <= '0;
    end else begin
      cp_q[0] <= '{vld: run_c && !cur_wr_c, addr: addr_q, elem: elem_q, exp: cur_exp_c};
      for (int i = 1; i < RD_LAT; i++) cp_q[i] <= cp_q[i-1];
    end
  end

  assign mis_c = cp_q[RD_LAT-1].vld && (rw0.RW0_rdata != cp_q[RD_LAT-1].exp);

  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) begin
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else if (mis_c) begin
      if (fail_cnt == '0) begin
        fail_addr <= cp_q[RD_LAT-1].addr;
        fail_elem <= cp_q[RD_LAT-1].elem;
        fail_exp  <= cp_q[RD_LAT-1].exp;
        fail_act  <= rw0.RW0_rdata;
      end
      if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = done && (fail_cnt == '0);
endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: behavioural registered SRAM wrapper with an injectable stuck-at cell,
// and an abstract March C- model predicting the op stream and the fail report.
module tb_sram_bist_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;
  localparam int N      = 16;
`ifdef SRAM_BIST_CHECKERBOARD_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int TOT  = 10 * N * NPASS;
  localparam int ENDK = TOT + RD_LAT + 1;

  logic              RW0_clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, pass;
  logic [15:0]       fail_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [DATA_W-1:0] fail_exp, fail_act;

  sram_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .RW0_clk   (RW0_clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_cnt  (fail_cnt),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_exp  (fail_exp),
    .fail_act  (fail_act),
    .rw0       (bus.master)
  );

  always #5 RW0_clk = ~RW0_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- wrapper model with one stuck-at cell ----------------
  bit                flt_on;
  int                flt_a, flt_b;
  bit                flt_v;
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] wd_r, rd_s1;

  function automatic logic [DATA_W-1:0] fview(input int a, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    if (flt_on && a == flt_a) r[flt_b] = flt_v;
    return r;
  endfunction

  always @(posedge RW0_clk) begin
    wd_r <= bus.RW0_wdata;
    if (bus.RW0_en && bus.RW0_wmode) mem[bus.RW0_addr] <= wd_r;
    rd_s1 <= fview(int'(bus.RW0_addr), mem[bus.RW0_addr]);
    bus.RW0_rdata <= rd_s1;
  end

  task automatic set_fault(input bit on, input int a, input int b, input bit v);
    flt_on = on;
    flt_a  = a;
    flt_b  = b;
    flt_v  = v;
  endtask

  // ---------------- abstract March C- reference ----------------
  typedef struct {
    bit                wr;
    int                addr;
    logic [DATA_W-1:0] dat;
  } op_t;

  op_t               expq[$];
  int                e_cnt, e_addr, e_elem;
  logic [DATA_W-1:0] e_exp, e_act;

  task automatic build_model();
    logic [DATA_W-1:0] img [N];
    logic [DATA_W-1:0] b, x, got;
    int a;
    bit hasr [6] = '{0, 1, 1, 1, 1, 1};
    bit hasw [6] = '{1, 1, 1, 1, 1, 0};
    bit rsym [6] = '{0, 0, 1, 0, 1, 0};
    bit wsym [6] = '{0, 1, 0, 1, 0, 0};
    expq.delete();
    e_cnt = 0; e_addr = 0; e_elem = 0; e_exp = '0; e_act = '0;
    for (int p = 0; p < NPASS; p++) begin
      b = (p == 1) ? 16'h5555 : 16'h0000;
      for (int e = 0; e < 6; e++) begin
        for (int i = 0; i < N; i++) begin
          a = (e == 3 || e == 4) ? N - 1 - i : i;
          if (hasr[e]) begin
            x = rsym[e] ? ~b : b;
            expq.push_back('{wr: 1'b0, addr: a, dat: x});
            got = fview(a, img[a]);
            if (got !== x) begin
              if (e_cnt == 0) begin
                e_addr = a; e_elem = e; e_exp = x; e_act = got;
              end
              if (e_cnt < 65535) e_cnt++;
            end
          end
          if (hasw[e]) begin
            x = wsym[e] ? ~b : b;
            img[a] = x;
            expq.push_back('{wr: 1'b1, addr: a, dat: x});
          end
        end
      end
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_en"},        32'(bus.RW0_en),    0);
    chk({t, "_wmode"},     32'(bus.RW0_wmode), 0);
    chk({t, "_addr"},      32'(bus.RW0_addr),  0);
    chk({t, "_wdata"},     32'(bus.RW0_wdata), 0);
    chk({t, "_busy"},      32'(busy),          0);
    chk({t, "_done"},      32'(done),          0);
    chk({t, "_pass"},      32'(pass),          0);
    chk({t, "_fail_cnt"},  32'(fail_cnt),      0);
    chk({t, "_fail_addr"}, 32'(fail_addr),     0);
    chk({t, "_fail_elem"}, 32'(fail_elem),     0);
    chk({t, "_fail_exp"},  32'(fail_exp),      0);
    chk({t, "_fail_act"},  32'(fail_act),      0);
  endtask

  // One test run. chain=1: start is already high in the current (DONE) cycle.
  // pulse_k: cycle t+k gets a spurious start; rst_k: reset asserted in cycle t+k.
  task automatic run_test(input bit chain, input int pulse_k, input int rst_k, input bit hold_next);
    logic [DATA_W-1:0] prev_wd;
    op_t op;
    build_model();
    if (!chain) begin
      repeat ($urandom_range(1, 4)) @(negedge RW0_clk);
      start = 1'b1;
    end
    #1;
    chk("t_en", 32'(bus.RW0_en), 0);
    chk("t_wdata", 32'(bus.RW0_wdata), 0);
    prev_wd = bus.RW0_wdata;
    for (int k = 1; k <= ENDK; k++) begin
      @(negedge RW0_clk);
      chk("busy", 32'(busy), 32'(k <= TOT + RD_LAT));
      chk("done", 32'(done), 32'(k == ENDK));
      if (k <= TOT) begin
        op = expq[k-1];
        chk("en", 32'(bus.RW0_en), 1);
        chk("wmode", 32'(bus.RW0_wmode), 32'(op.wr));
        chk("addr", 32'(bus.RW0_addr), 32'(op.addr));
        if (op.wr) chk("wdata_lead", 32'(prev_wd), 32'(op.dat));
      end else begin
        chk("drain_en", 32'(bus.RW0_en), 0);
        chk("drain_wmode", 32'(bus.RW0_wmode), 0);
      end
      if (k == ENDK) begin
        chk("pass", 32'(pass), 32'(e_cnt == 0));
        chk("fail_cnt", 32'(fail_cnt), 32'(e_cnt));
        if (e_cnt > 0) begin
          chk("fail_addr", 32'(fail_addr), 32'(e_addr));
          chk("fail_elem", 32'(fail_elem), 32'(e_elem));
          chk("fail_exp", 32'(fail_exp), 32'(e_exp));
          chk("fail_act", 32'(fail_act), 32'(e_act));
        end
      end
      prev_wd = bus.RW0_wdata;
      start = (k == pulse_k) || (k == ENDK && hold_next);
      if (k == rst_k) begin
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge RW0_clk);
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_fault(0, 0, 0, 0);
    repeat (3) @(negedge RW0_clk);
    chk_zero("reset");
    rst = 1'b0;

    run_test(0, 0, 0, 0);
    set_fault(1, 5, 3, 1);
    run_test(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_fault(1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, DATA_W - 1)),
                bit'($urandom_range(0, 1)));
      run_test(0, (i == 0) ? int'($urandom_range(1, TOT)) : 0, 0, i == 2);
    end
    set_fault(1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, DATA_W - 1)),
              bit'($urandom_range(0, 1)));
    run_test(1, 0, 0, 0);
    set_fault(1, 5, 3, 1);
    run_test(0, 0, int'($urandom_range(3 * N + 1, 5 * N)), 0);
    set_fault(0, 0, 0, 0);
    run_test(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
